uop_buffer: RTL
===============

Name: uop_buffer

Overview:
- Storage and responder end of the uop buffer read interface, driven by the uop fetch stage.
- Write side: accepts a stream of 32-bit instructions over a valid/ready handshake and packs them in pairs into UOP_BUF_WIDTH-bit words. The earlier instruction goes in bits [31:0], the later one in bits [63:32].
- Read side: returns the word at the requested address with a fixed one-cycle latency.
- Sits between the program loader and uop fetch; it is the only owner of uop buffer memory.

Parameters:
- UOP_BUF_SIZE, 128, number of packed words in the buffer.
- UOP_BUF_WIDTH, 64, word width; fixed to two 32-bit instructions.
- NOP_INSN, 32'h0000_0000, filler used for an odd trailing half-word and for reads of unloaded slots.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of load state, same effect as reset on control state; memory array untouched.
- in_valid  input  1  loader instruction valid.
- in_ready  output  1  buffer can accept an instruction this cycle.
- in_insn  input  32  instruction.
- in_last  input  1  marks final instruction of the program; qualified by in_valid.
- uop_addr  input  $clog2(UOP_BUF_SIZE)  read address from fetch.
- uop  output  UOP_BUF_WIDTH  registered read data.
- word_count  output  $clog2(UOP_BUF_SIZE)+1  number of words written.
- loaded  output  1  program fully loaded (DONE state).
- overflow  output  1  buffer filled before in_last was seen.

Behaviour:
- Clock and reset: clk; reset is synchronous and active-high. reset has priority over clear, and clear has priority over everything else.
- Reset / clear values:
  - state=FILL_LO, wr_ptr=0, word_count=0, loaded=0, overflow=0, lo_hold=0.
  - uop=0 on reset. clear leaves uop unchanged.
  - Memory contents are not initialised.
- Handshake:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state != DONE) && (wr_ptr < UOP_BUF_SIZE), combinational from registered state only.
- FSM:
  - FILL_LO, transfer with !in_last: lo_hold<=in_insn; go to FILL_HI.
  - FILL_LO, transfer with in_last: mem[wr_ptr]<={NOP_INSN,in_insn}; wr_ptr++; go to DONE.
  - FILL_HI, transfer: mem[wr_ptr]<={in_insn,lo_hold}; wr_ptr++. Go to DONE if in_last, else FILL_LO.
  - After any write that makes wr_ptr==UOP_BUF_SIZE without in_last: go to DONE, overflow<=1. Any lo_hold content is discarded.
  - DONE: no transfers. Leave only via reset or clear.
  - loaded = (state==DONE).
  - word_count = wr_ptr. Exactly one word is written per completed pair, or per odd trailing instruction.
- Read port:
  - Every cycle, uop <= (uop_addr < word_count) ? mem[uop_addr] : {NOP_INSN,NOP_INSN}. word_count here is the value before this edge's update.
  - Latency is exactly 1 cycle. No enable; fetch stalls by holding uop_addr.
  - Read and write to the same address in the same cycle returns old data. Because of the word_count guard, that is the NOP pair.
- Pointer arithmetic: wr_ptr is one bit wider than the address. The write index is wr_ptr[$clog2(UOP_BUF_SIZE)-1:0]. It never wraps; the buffer saturates at UOP_BUF_SIZE.
- Mid-load clear/reset: any partial pair in lo_hold is dropped. The next accepted instruction becomes the low half of word 0.
- in_last on an odd position always pads the high half with NOP_INSN.

Test Plan:
- Packing: reset, then stream 0x11,0x22,0x33,0x44 with in_last on 0x44 -> word_count=2, loaded=1; read addr 0 -> uop=0x00000022_00000011; addr 1 -> 0x00000044_00000033; in_ready=0.
- Odd tail: stream 0xA,0xB,0xC with in_last on 0xC -> word_count=2; addr 1 -> 0x00000000_0000000C.
- Backpressure and latency: hold in_valid=1 with in_last=0, UOP_BUF_SIZE=4, 8 instructions -> in_ready=1 for 8 cycles then 0; overflow=1, loaded=1, word_count=4. A read issued at cycle N presents data at cycle N+1.
- Unloaded reads and read-during-write: after 1 word loaded, read addr 3 -> NOP pair. Read addr 1 on the same edge that writes word 1 -> NOP pair; the next cycle returns the new word.
- Clear mid-load: send 0x5 (held in lo_hold), assert clear, then send 0x6,0x7 with in_last on 0x7 -> word 0 = 0x00000007_00000006; word_count=1.
- Reset priority: assert reset and clear together during DONE -> all control outputs at reset values, uop=0, in_ready=1 the next cycle.

Source files
------------

// File: rtl/uop_buffer_if.sv
// Loader write handshake and fetch read port of the uop buffer.
// The master side is the loader/fetch pair; the buffer itself is the slave.
interface uop_buffer_if #(
  parameter int unsigned UOP_BUF_SIZE  = 128,
  parameter int unsigned UOP_BUF_WIDTH = 64
) ();
  logic                            in_valid;
  logic                            in_ready;
  logic [31:0]                     in_insn;
  logic                            in_last;
  logic [$clog2(UOP_BUF_SIZE)-1:0] uop_addr;
  logic [UOP_BUF_WIDTH-1:0]        uop;

  modport master (
    output in_valid, in_insn, in_last, uop_addr,
    input  in_ready, uop
  );

  modport slave (
    input  in_valid, in_insn, in_last, uop_addr,
    output in_ready, uop
  );
endinterface

// File: rtl/uop_buffer.sv
// Uop buffer: packs loader instructions in pairs into words and serves
// fetch reads with a fixed one-cycle latency.
module uop_buffer #(
  parameter int unsigned UOP_BUF_SIZE  = 128,
  parameter int unsigned UOP_BUF_WIDTH = 64,
  parameter logic [31:0] NOP_INSN      = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  uop_buffer_if.slave                     bus,
  output logic [$clog2(UOP_BUF_SIZE):0]   word_count,
  output logic                            loaded,
  output logic                            overflow
);
  localparam int unsigned AW = $clog2(UOP_BUF_SIZE);

  typedef enum logic [1:0] {
    FILL_LO,
    FILL_HI,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [AW:0]              wr_ptr_q, wr_ptr_d;
  logic [31:0]              lo_hold_q, lo_hold_d;
  logic                     overflow_q, overflow_d;
  logic [UOP_BUF_WIDTH-1:0] uop_q;
  logic [UOP_BUF_WIDTH-1:0] mem [UOP_BUF_SIZE];

  logic                     fire;
  logic                     mem_we;
  logic [UOP_BUF_WIDTH-1:0] mem_wdata;

  assign bus.in_ready = (state_q != DONE) && (wr_ptr_q < (AW+1)'(UOP_BUF_SIZE));
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    lo_hold_d  = lo_hold_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    unique case (state_q)
      FILL_LO: begin
        if (fire) begin
          if (bus.in_last) begin
            mem_we    = 1'b1;
            mem_wdata = {NOP_INSN, bus.in_insn};
            wr_ptr_d  = wr_ptr_q + 1'b1;
            state_d   = DONE;
          end else begin
            lo_hold_d = bus.in_insn;
            state_d   = FILL_HI;
          end
        end
      end
      FILL_HI: begin
        if (fire) begin
          mem_we    = 1'b1;
          mem_wdata = {bus.in_insn, lo_hold_q};
          wr_ptr_d  = wr_ptr_q + 1'b1;
          state_d   = bus.in_last ? DONE : FILL_LO;
        end
      end
      default: ;
    endcase
    // Saturation: filling the last slot without in_last ends the load.
    if (mem_we && !bus.in_last && (wr_ptr_d == (AW+1)'(UOP_BUF_SIZE))) begin
      state_d    = DONE;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL_LO;
      wr_ptr_q   <= '0;
      lo_hold_q  <= '0;
      overflow_q <= 1'b0;
      uop_q      <= '0;
    end else if (clear) begin
      state_q    <= FILL_LO;
      wr_ptr_q   <= '0;
      lo_hold_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      lo_hold_q  <= lo_hold_d;
      overflow_q <= overflow_d;
      // Guard uses the pre-update count, so a same-edge write reads as NOP.
      uop_q      <= ({1'b0, bus.uop_addr} < wr_ptr_q) ? mem[bus.uop_addr]
                                                      : {NOP_INSN, NOP_INSN};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset && !clear) begin
      mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

  assign bus.uop    = uop_q;
  assign word_count = wr_ptr_q;
  assign loaded     = (state_q == DONE);
  assign overflow   = overflow_q;
endmodule
